mem_rd_ctrl: RTL and testbench

//  Read-side controller for the single-packet buffer RAM. Once the write-side controller reports a stored packet, this block reads it out in address order.
//  It presents the words as a sop/eop/val stream with ready back-pressure, then pulses clr_o so the write side resets its address and busy flag.
//  It sits between the buffer RAM read port and the downstream packet sink.

---
 rtl/mem_rd_ctrl_pkg.sv | 19 +
 rtl/mem_rd_ctrl_if.sv | 37 +++
 rtl/mem_rd_ctrl_skid.sv | 57 +++++
 rtl/mem_rd_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_rd_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_rd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the packet-buffer read-side controller.
//   rd_state_t  : read FSM states (IDLE -> READ -> CLEAR -> IDLE)
//   RAM_RD_LAT  : buffer RAM read latency in cycles (q valid the cycle after rden)
//   SKID_DEPTH  : number of entries in the read-return skid FIFO
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CLEAR = 2'd2
    } rd_state_t;

    localparam int RAM_RD_LAT = 1;
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/mem_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_rd_ctrl_if
// Packet stream between the read-side controller and the downstream sink.
//   data  : stream word
//   val   : word valid
//   sop   : first word of packet (qualified by val)
//   eop   : last word of packet (qualified by val)
//   ready : sink accepts; a transfer happens when val & ready
// Modports: master = packet source (controller), slave = packet sink.
// ---------------------------------------------------------------------------
interface mem_rd_ctrl_if #(
    parameter int DWIDTH = 8
);

    logic [DWIDTH-1:0] data;
    logic              val;
    logic              sop;
    logic              eop;
    logic              ready;

    modport master (
        output data,
        output val,
        output sop,
        output eop,
        input  ready
    );

    modport slave (
        input  data,
        input  val,
        input  sop,
        input  eop,
        output ready
    );

endinterface

// File: rtl/mem_rd_ctrl_skid.sv
// ---------------------------------------------------------------------------
// mem_rd_skid
// Two-entry FIFO that catches RAM read data so the stream can stall without
// losing words that are already in flight from the registered RAM.
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   wr_i, data_i    : push one word
//   rd_i            : pop the head word (only when not empty)
//   data_o          : head word (0 after reset)
//   empty_o         : no words stored
//   usedw_o         : number of words stored (0..2)
// ---------------------------------------------------------------------------
module mem_rd_skid #(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              wr_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rd_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              empty_o,
    output logic [1:0]        usedw_o
);

    logic [DWIDTH-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({wr_i, rd_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign usedw_o = count_q;

endmodule

// File: rtl/mem_rd_ctrl.sv
// ---------------------------------------------------------------------------
// mem_rd_ctrl
// Read-side controller for the single-packet buffer RAM. When the write side
// reports a stored packet it reads the words out in address order, streams
// them with sop/eop/val and ready back-pressure, then pulses clr_o so the
// write side can reset its address and busy flag.
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   busy_i          : write side holds a complete packet
//   wraddr_i        : number of stored words (0 means a full 2**AWIDTH)
//   rden_o/rdaddr_o : RAM read port request
//   rddata_i        : RAM q, valid the cycle after rden_o
//   strm            : packet stream towards the sink (master side)
//   clr_o           : one-cycle pulse after the last transfer
//   rd_busy_o       : high from leaving IDLE through the CLEAR cycle
// ---------------------------------------------------------------------------
module mem_rd_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              busy_i,
    input  logic [AWIDTH-1:0] wraddr_i,
    output logic              rden_o,
    output logic [AWIDTH-1:0] rdaddr_o,
    input  logic [DWIDTH-1:0] rddata_i,
    output logic              clr_o,
    output logic              rd_busy_o,
    mem_rd_ctrl_if.master     strm
);

    localparam logic [AWIDTH:0] FULL_LEN = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] LEN_ONE  = (AWIDTH+1)'(1);

    rd_state_t         state_q;
    logic [AWIDTH:0]   len_q;
    logic [AWIDTH:0]   issued_q;
    logic [AWIDTH:0]   sent_q;
    logic [AWIDTH-1:0] rdaddr_q;
    logic              rd_vld_q;
    logic              clr_q;
    logic              rd_busy_q;

    logic [DWIDTH-1:0] head_data;
    logic              fifo_empty;
    logic [1:0]        fifo_used;
    logic              val;
    logic              pop;
    logic              rden;
    logic              last_xfer;
    logic [2:0]        occupancy;

    // Words already committed to the skid FIFO once this cycle settles:
    // stored entries plus the RAM word arriving now, minus the word leaving.
    // Counting the pop lets a new read issue every cycle while the sink is
    // ready, yet the FIFO can never be pushed past two entries on a stall.
    assign occupancy = {1'b0, fifo_used} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign rden      = (state_q == READ) && (issued_q < len_q)
                       && (occupancy < 3'(SKID_DEPTH));

    assign val       = (state_q == READ) && !fifo_empty;
    assign pop       = val && strm.ready;
    assign last_xfer = pop && strm.eop;

    assign strm.data = head_data;
    assign strm.val  = val;
    assign strm.sop  = val && (sent_q == '0);
    assign strm.eop  = val && (sent_q == (len_q - LEN_ONE));

    assign rden_o    = rden;
    assign rdaddr_o  = rdaddr_q;
    assign clr_o     = clr_q;
    assign rd_busy_o = rd_busy_q;

    // RAM q arrives RAM_RD_LAT (one) cycle after the request, so the push
    // strobe is simply the read enable delayed by one register.
    mem_rd_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .wr_i     (rd_vld_q),
        .data_i   (rddata_i),
        .rd_i     (pop),
        .data_o   (head_data),
        .empty_o  (fifo_empty),
        .usedw_o  (fifo_used)
    );

    // Packet FSM. The length is latched once on entry to READ; busy_i and
    // wraddr_i are ignored until the controller is back in IDLE, and busy_i
    // has already dropped by then because the write side clears on clr_o.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            rdaddr_q  <= '0;
            rd_vld_q  <= 1'b0;
            clr_q     <= 1'b0;
            rd_busy_q <= 1'b0;
        end else begin
            rd_vld_q <= rden;
            clr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (busy_i) begin
                        len_q     <= (wraddr_i == '0) ? FULL_LEN : {1'b0, wraddr_i};
                        rdaddr_q  <= '0;
                        issued_q  <= '0;
                        sent_q    <= '0;
                        rd_busy_q <= 1'b1;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    // A full-depth packet wraps rdaddr back to 0 after the
                    // final issue; that address is never used.
                    if (rden) begin
                        rdaddr_q <= rdaddr_q + 1'b1;
                        issued_q <= issued_q + 1'b1;
                    end
                    if (pop) begin
                        sent_q <= sent_q + 1'b1;
                    end
                    if (last_xfer) begin
                        clr_q   <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    rd_busy_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_ctrl
// Bench for mem_rd_ctrl: a behavioural buffer RAM, a write-side model that
// drops busy after clr_o, a scoreboard of expected stream words and a
// monitor that checks every transfer, stall hold, clr_o timing and latency.
// ---------------------------------------------------------------------------
module tb_mem_rd_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    logic       clk;
    logic       arst_n;
    logic       busy;
    logic [3:0] wraddr;
    logic       rden;
    logic [3:0] rdaddr;
    logic [7:0] rddata;
    logic       clr;
    logic       rd_busy;

    mem_rd_ctrl_if #(.DWIDTH(8)) strm ();

    mem_rd_ctrl #(
        .AWIDTH (4),
        .DWIDTH (8)
    ) dut (
        .clk_i     (clk),
        .arst_n_i  (arst_n),
        .busy_i    (busy),
        .wraddr_i  (wraddr),
        .rden_o    (rden),
        .rdaddr_o  (rdaddr),
        .rddata_i  (rddata),
        .clr_o     (clr),
        .rd_busy_o (rd_busy),
        .strm      (strm.master)
    );

    logic [7:0] mem [16];
    exp_t       sb [$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int clr_cnt     = 0;
    int xfer_cnt    = 0;
    int eop_cyc     = -10;
    int last_xfer   = -10;
    int start_cyc   = 0;
    int ready_mode  = 0;
    bit lat_pending = 0;

    logic [31:0] rpat = 32'b1100_1011_0000_0000_1101_0010_0000_1011;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Registered buffer RAM: q is valid the cycle after the read request.
    always @(posedge clk) begin
        if (rden) rddata <= mem[rdaddr];
    end

    // Write-side model: busy falls at the edge that ends the CLEAR cycle.
    initial forever begin
        @(negedge clk);
        if (clr) begin
            @(posedge clk);
            #1;
            busy = 1'b0;
        end
    end

    // Sink ready: always ready, or a fixed rotating pattern with long stalls.
    initial begin
        strm.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                strm.ready = rpat[0];
                rpat       = {rpat[0], rpat[31:1]};
            end else begin
                strm.ready = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Monitor: compares transfers against the scoreboard, checks that stalled
    // words hold, that clr_o follows the eop transfer and the first-word latency.
    bit         held;
    logic [7:0] held_data;
    logic       held_sop;
    logic       held_eop;

    initial begin
        exp_t e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checkOutput("stall_val", int'(strm.val), 1);
                    checkOutput("stall_data", int'(strm.data), int'(held_data));
                    checkOutput("stall_sop", int'(strm.sop), int'(held_sop));
                    checkOutput("stall_eop", int'(strm.eop), int'(held_eop));
                end
                held      = strm.val && !strm.ready;
                held_data = strm.data;
                held_sop  = strm.sop;
                held_eop  = strm.eop;

                if (lat_pending && strm.val) begin
                    checkOutput("first_word_latency", cyc - start_cyc, 3);
                    lat_pending = 1'b0;
                end

                if (clr) begin
                    clr_cnt++;
                    checkOutput("clr_after_eop", cyc, eop_cyc + 1);
                    checkOutput("val_in_clear", int'(strm.val), 0);
                end

                if (strm.val && strm.ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_word actual=%0d expected=none", strm.data);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("word_data", int'(strm.data), int'(e.data));
                        checkOutput("word_sop", int'(strm.sop), int'(e.sop));
                        checkOutput("word_eop", int'(strm.eop), int'(e.eop));
                        if (ready_mode == 0 && !e.sop)
                            checkOutput("back_to_back", cyc, last_xfer + 1);
                        if (e.eop) eop_cyc = cyc;
                    end
                    last_xfer = cyc;
                    xfer_cnt++;
                end
            end
        end
    end

    // Launch one packet of wr words (0 = full depth) and wait for its clr_o.
    task automatic applyStimulus(input int wr, input int mode);
        int plen;
        int c0;
        plen = (wr == 0) ? 16 : wr;
        for (int i = 0; i < plen; i++)
            sb.push_back('{data: mem[i], sop: (i == 0), eop: (i == plen - 1)});
        ready_mode = mode;
        c0 = clr_cnt;
        @(posedge clk);
        #1;
        wraddr      = 4'(wr);
        busy        = 1'b1;
        start_cyc   = cyc;
        lat_pending = 1'b1;
        for (int i = 0; i < 600 && clr_cnt == c0; i++) begin
            @(negedge clk);
            #1;
        end
        if (clr_cnt == c0) begin
            checks++;
            failures++;
            $display("[TB] FAIL packet_timeout actual=%0d expected=%0d words", plen - sb.size(), plen);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("clr_pulse_count", clr_cnt - c0, 1);
        checkOutput("scoreboard_empty", sb.size(), 0);
        checkOutput("rd_busy_idle", int'(rd_busy), 0);
        ready_mode = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h5A ^ 8'(i * 37);
        arst_n = 1'b0;
        busy   = 1'b0;
        wraddr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_val", int'(strm.val), 0);
        checkOutput("reset_rden", int'(rden), 0);
        checkOutput("reset_rdaddr", int'(rdaddr), 0);
        checkOutput("reset_data", int'(strm.data), 0);
        checkOutput("reset_sop", int'(strm.sop), 0);
        checkOutput("reset_eop", int'(strm.eop), 0);
        checkOutput("reset_clr", int'(clr), 0);
        checkOutput("reset_rd_busy", int'(rd_busy), 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] packet of 5, sink always ready");
        applyStimulus(5, 0);
        $display("[TB] full-depth packet (wraddr wrapped to 0)");
        applyStimulus(0, 0);
        $display("[TB] single-word packet");
        applyStimulus(1, 0);
        $display("[TB] packet of 8 with stalling sink");
        applyStimulus(8, 1);

        $display("[TB] reset in the middle of a packet of 8");
        for (int i = 0; i < 8; i++)
            sb.push_back('{data: mem[i], sop: (i == 0), eop: (i == 7)});
        ready_mode = 0;
        c0 = xfer_cnt;
        @(posedge clk);
        #1;
        wraddr      = 4'd8;
        busy        = 1'b1;
        start_cyc   = cyc;
        lat_pending = 1'b1;
        for (int i = 0; i < 100 && xfer_cnt < c0 + 4; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("xfers_before_reset", xfer_cnt - c0, 4);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        busy   = 1'b0;
        #1;
        checkOutput("midreset_val", int'(strm.val), 0);
        checkOutput("midreset_rden", int'(rden), 0);
        checkOutput("midreset_clr", int'(clr), 0);
        checkOutput("midreset_rd_busy", int'(rd_busy), 0);
        sb.delete();
        lat_pending = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        applyStimulus(4, 0);

        $display("[TB] back-to-back packets of 3 and 6");
        applyStimulus(3, 0);
        applyStimulus(6, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
